// File: rtl/alu_ctrl_issue.sv
// ============================================================================
// Module   : alu_ctrl_issue
// Brief    : Decodes MIPS opcode/funct into the 6-bit ALU control code at the
//            ID/EX boundary; holds mult/div codes for a configurable count.
// Revision : 1.0
// ============================================================================
`default_nettype none

module alu_ctrl_issue #(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       stall,
  input  logic       flush,
  output logic [5:0] alu_ctrl,
  output logic       out_valid,
  output logic       busy,
  output logic       illegal
);

  localparam logic [5:0] C_ADD  = 6'b000000;
  localparam logic [5:0] C_SUB  = 6'b000001;
  localparam logic [5:0] C_MULT = 6'b000010;
  localparam logic [5:0] C_DIV  = 6'b000011;
  localparam logic [5:0] C_OR   = 6'b000100;
  localparam logic [5:0] C_AND  = 6'b000101;
  localparam logic [5:0] C_SLT  = 6'b000111;
  localparam logic [5:0] C_XOR  = 6'b001000;
  localparam logic [5:0] C_NOR  = 6'b001001;
  localparam logic [5:0] C_JAL  = 6'b100000;

  localparam bit         MUL_MC   = (MUL_CYCLES > 1);
  localparam bit         DIV_MC   = (DIV_CYCLES > 1);
  localparam logic [4:0] MUL_LOAD = MUL_MC ? 5'(MUL_CYCLES - 2) : 5'd0;
  localparam logic [4:0] DIV_LOAD = DIV_MC ? 5'(DIV_CYCLES - 2) : 5'd0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [4:0] cnt_q, cnt_d;
  logic [5:0] ctrl_q, ctrl_d;
  logic       ill_q, ill_d;

  logic [5:0] dec_ctrl;
  logic       dec_ill;
  logic       dec_mul;
  logic       dec_div;
  logic       accept;

  always_comb begin
    dec_ctrl = C_ADD;
    dec_ill  = 1'b0;
    dec_mul  = 1'b0;
    dec_div  = 1'b0;
    if (opcode == 6'b000000) begin
      case (funct)
        6'b100000, 6'b100001: dec_ctrl = C_ADD;
        6'b100010, 6'b100011: dec_ctrl = C_SUB;
        6'b100100:            dec_ctrl = C_AND;
        6'b100101:            dec_ctrl = C_OR;
        6'b100110:            dec_ctrl = C_XOR;
        6'b100111:            dec_ctrl = C_NOR;
        6'b101010:            dec_ctrl = C_SLT;
        6'b011000: begin
          dec_ctrl = C_MULT;
          dec_mul  = 1'b1;
        end
        6'b011010: begin
          dec_ctrl = C_DIV;
          dec_div  = 1'b1;
        end
        default:              dec_ill  = 1'b1;
      endcase
    end else begin
      case (opcode)
        6'b001000, 6'b001001: dec_ctrl = C_ADD;
        6'b001100:            dec_ctrl = C_AND;
        6'b001101:            dec_ctrl = C_OR;
        6'b001110:            dec_ctrl = C_XOR;
        6'b001010:            dec_ctrl = C_SLT;
        6'b100011, 6'b101011: dec_ctrl = C_ADD;
        6'b000100, 6'b000101: dec_ctrl = C_SUB;
        6'b000011:            dec_ctrl = C_JAL;
        default:              dec_ill  = 1'b1;
      endcase
    end
  end

  assign in_ready = !stall && !flush && (state_q != S_HOLD);
  assign accept   = in_valid && in_ready;

  // Flush outranks stall; stall freezes everything, so accept is already gated.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ctrl_d  = ctrl_q;
    ill_d   = ill_q;
    if (flush) begin
      state_d = S_IDLE;
      cnt_d   = 5'd0;
      ctrl_d  = C_ADD;
      ill_d   = 1'b0;
    end else if (!stall) begin
      case (state_q)
        S_HOLD: begin
          if (cnt_q == 5'd0) begin
            state_d = S_EXEC;
          end else begin
            cnt_d = cnt_q - 5'd1;
          end
        end
        default: begin
          if (accept) begin
            ctrl_d = dec_ctrl;
            ill_d  = dec_ill;
            cnt_d  = 5'd0;
            if (dec_mul && MUL_MC) begin
              state_d = S_HOLD;
              cnt_d   = MUL_LOAD;
            end else if (dec_div && DIV_MC) begin
              state_d = S_HOLD;
              cnt_d   = DIV_LOAD;
            end else begin
              state_d = S_EXEC;
            end
          end else begin
            state_d = S_IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 5'd0;
      ctrl_q  <= C_ADD;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ctrl_q  <= ctrl_d;
      ill_q   <= ill_d;
    end
  end

  assign alu_ctrl  = ctrl_q;
  assign out_valid = (state_q == S_EXEC) && !stall;
  assign busy      = (state_q == S_HOLD);
  assign illegal   = ill_q && out_valid;

endmodule

`default_nettype wire

// File: tb/tb_alu_ctrl_issue.sv
// ============================================================================
// Module   : tb_alu_ctrl_issue
// Brief    : Scoreboard bench for alu_ctrl_issue with directed vectors.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_alu_ctrl_issue;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       stall;
  logic       flush;
  logic [5:0] alu_ctrl;
  logic       out_valid;
  logic       busy;
  logic       illegal;

  int checks = 0;
  int errors = 0;
  logic [6:0] sb_q[$];

  alu_ctrl_issue #(.MUL_CYCLES(4), .DIV_CYCLES(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .opcode   (opcode),
    .funct    (funct),
    .stall    (stall),
    .flush    (flush),
    .alu_ctrl (alu_ctrl),
    .out_valid(out_valid),
    .busy     (busy),
    .illegal  (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive an instruction and record what the ALU should eventually see.
  task automatic offer(input logic [5:0] op, input logic [5:0] fn,
                       input logic [5:0] exp_ctrl, input logic exp_ill, input bit push);
    in_valid = 1'b1;
    opcode   = op;
    funct    = fn;
    if (push) sb_q.push_back({exp_ill, exp_ctrl});
  endtask

  // Monitor: every out_valid pulse must match the oldest outstanding op.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      logic [6:0] e;
      chk("no_out_valid_during_stall", {31'd0, stall}, 32'd0);
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out_valid: got alu_ctrl=%0h with empty scoreboard at %0t",
                 alu_ctrl, $time);
      end else begin
        e = sb_q.pop_front();
        if (alu_ctrl !== e[5:0] || illegal !== e[6]) begin
          errors++;
          $display("FAIL sb_result: got ctrl=%b ill=%b expected ctrl=%b ill=%b at %0t",
                   alu_ctrl, illegal, e[5:0], e[6], $time);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int n3, nov;
    rst_n = 1'b0; in_valid = 1'b0; opcode = '0; funct = '0; stall = 1'b0; flush = 1'b0;
    #12;
    chk("rst_alu_ctrl", {26'd0, alu_ctrl}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_illegal", {31'd0, illegal}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    rst_n = 1'b1;
    step();

    // Back-to-back add, sub
    offer(6'b000000, 6'b100000, 6'b000000, 1'b0, 1'b1);
    @(negedge clk); chk("add_in_ready", {31'd0, in_ready}, 32'd1);
    step();
    offer(6'b000000, 6'b100010, 6'b000001, 1'b0, 1'b1);
    @(negedge clk);
    chk("add_out_valid", {31'd0, out_valid}, 32'd1);
    chk("sub_in_ready", {31'd0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    @(negedge clk); chk("sub_ctrl", {26'd0, alu_ctrl}, 32'd1);
    step();
    @(negedge clk); chk("idle_out_valid", {31'd0, out_valid}, 32'd0);

    // mult held 4 cycles, or queued behind it
    step();
    offer(6'b000000, 6'b011000, 6'b000010, 1'b0, 1'b1);
    step();
    offer(6'b001101, 6'b000000, 6'b000100, 1'b0, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      chk("mul_ctrl", {26'd0, alu_ctrl}, 32'd2);
      chk("mul_busy", {31'd0, busy}, (i < 4) ? 32'd1 : 32'd0);
      chk("mul_in_ready", {31'd0, in_ready}, (i < 4) ? 32'd0 : 32'd1);
      chk("mul_out_valid", {31'd0, out_valid}, (i == 4) ? 32'd1 : 32'd0);
      step();
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("or_ctrl", {26'd0, alu_ctrl}, 32'd4);
    chk("or_out_valid", {31'd0, out_valid}, 32'd1);
    step();

    // div with a 3-cycle stall mid-hold: 11 cycles total
    offer(6'b000000, 6'b011010, 6'b000011, 1'b0, 1'b1);
    step();
    in_valid = 1'b0;
    n3 = 0; nov = 0;
    for (int i = 1; i <= 11; i++) begin
      stall = (i >= 3 && i <= 5);
      @(negedge clk);
      if (alu_ctrl == 6'b000011) n3++;
      if (out_valid) nov++;
      chk("div_busy", {31'd0, busy}, (i < 11) ? 32'd1 : 32'd0);
      chk("div_out_valid", {31'd0, out_valid}, (i == 11) ? 32'd1 : 32'd0);
      step();
    end
    stall = 1'b0;
    chk("div_hold_cycles", n3, 32'd11);
    chk("div_out_valid_count", nov, 32'd1);
    @(negedge clk);
    chk("idle_holds_ctrl", {26'd0, alu_ctrl}, 32'd3);
    chk("idle_no_valid", {31'd0, out_valid}, 32'd0);
    step();

    // flush in 2nd cycle of mult: no output, back to idle
    offer(6'b000000, 6'b011000, 6'b000010, 1'b0, 1'b0);
    step();
    in_valid = 1'b0;
    step();
    flush = 1'b1;
    @(negedge clk); chk("flush_in_ready", {31'd0, in_ready}, 32'd0);
    step();
    flush = 1'b0;
    @(negedge clk);
    chk("flush_busy", {31'd0, busy}, 32'd0);
    chk("flush_ctrl", {26'd0, alu_ctrl}, 32'd0);
    chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
    repeat (4) step();

    // illegal, jal, beq back-to-back
    offer(6'b111111, 6'b000000, 6'b000000, 1'b1, 1'b1);
    step();
    offer(6'b000011, 6'b000000, 6'b100000, 1'b0, 1'b1);
    @(negedge clk); chk("illegal_flag", {31'd0, illegal}, 32'd1);
    step();
    offer(6'b000100, 6'b000000, 6'b000001, 1'b0, 1'b1);
    @(negedge clk);
    chk("jal_ctrl", {26'd0, alu_ctrl}, 32'h20);
    chk("jal_illegal", {31'd0, illegal}, 32'd0);
    step();
    in_valid = 1'b0;
    @(negedge clk); chk("beq_ctrl", {26'd0, alu_ctrl}, 32'd1);
    step();

    // async reset mid-div
    offer(6'b000000, 6'b011010, 6'b000011, 1'b0, 1'b0);
    step();
    in_valid = 1'b0;
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ctrl", {26'd0, alu_ctrl}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    #2 rst_n = 1'b1;
    offer(6'b000000, 6'b100001, 6'b000000, 1'b0, 1'b1);
    step();
    in_valid = 1'b0;
    @(negedge clk); chk("post_rst_add_valid", {31'd0, out_valid}, 32'd1);
    repeat (3) step();

    chk("scoreboard_drained", sb_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/alu_ctrl_issue.md
Name: alu_ctrl_issue

Overview:
Producer side of the 6-bit ALU control interface. Decodes MIPS opcode/funct into the ALU operation code and registers it at the ID/EX boundary. Holds mult/div codes stable for a parameterised number of cycles so the ALU's combinational multiply/divide path is treated as multicycle. Sits between the decode stage and the ALU, with a valid/ready handshake toward decode.

Parameters:
MUL_CYCLES, 4, cycles mult code is held (legal 1..32; 1 = single-cycle)
DIV_CYCLES, 8, cycles div code is held (legal 1..32; 1 = single-cycle)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  decode presents an instruction
in_ready  output  1  block accepts instruction this cycle (combinational)
opcode  input  6  instruction[31:26]
funct  input  6  instruction[5:0], used when opcode==000000
stall  input  1  downstream freeze
flush  input  1  synchronous abort of in-flight op
alu_ctrl  output  6  ALU operation code (registered)
out_valid  output  1  alu_ctrl valid, ALU result to be sampled this cycle
busy  output  1  multicycle op in progress, not final cycle
illegal  output  1  unrecognised opcode/funct, qualified by out_valid

Behaviour:
- Codes: add 000000, sub 000001, mult 000010, div 000011, or 000100, and 000101, not 000110, slt 000111, xor 001000, nor 001001, xnor 001010, jal 100000.
- R-type (opcode 000000), by funct: 100000/100001 add; 100010/100011 sub; 100100 and; 100101 or; 100110 xor; 100111 nor; 101010 slt; 011000 mult; 011010 div.
- I/J-type, by opcode: 001000/001001 add; 001100 and; 001101 or; 001110 xor; 001010 slt; 100011 (lw)/101011 (sw) add; 000100/000101 (beq/bne) sub; 000011 jal.
- not/xnor are never generated by this decoder.
- Anything else: alu_ctrl=000000, illegal=1 in its out_valid cycle.
- States: IDLE, EXEC (final/only cycle; out_valid possible), HOLD (multicycle, non-final).
- in_ready = !stall & !flush & (state != HOLD).
- Accept = in_valid & in_ready at a rising edge; code, illegal and state are loaded at that edge.
- Single-cycle op, or MUL_CYCLES/DIV_CYCLES==1: next state EXEC. Latency 1: out_valid high in the cycle after accept.
- Mult/div with N>1: next state HOLD, cnt=N-2. HOLD decrements cnt each unstalled cycle. At cnt==0 it moves to EXEC. Code is held for exactly N cycles; out_valid is high in the Nth only.
- EXEC with a new accept reloads (back-to-back, one op per cycle). EXEC without accept goes to IDLE.
- alu_ctrl holds its last value in IDLE.
- out_valid = (state==EXEC) & !stall. busy = (state==HOLD). illegal output = illegal_reg & out_valid.
- stall high: state, cnt, alu_ctrl and illegal_reg all frozen. No accept; HOLD count does not advance.
- flush high (priority over stall and accept): next state IDLE, cnt=0, alu_ctrl=000000, illegal_reg=0. The in-flight op is never marked out_valid.
- Reset (async, any time including mid-HOLD): state IDLE, alu_ctrl=000000, out_valid=0, busy=0, illegal=0, cnt=0, in_ready=1 (when stall=flush=0).
- Decode uses only opcode/funct sampled at accept; inputs may change freely when not accepted.

Test Plan:
- Reset then opcode=000000 funct=100000 (add) accepted at edge 1 -> alu_ctrl=000000, out_valid=1 at cycle 1. Next cycle sub (funct 100010) accepted -> alu_ctrl=000001, out_valid=1; in_ready stays 1 throughout.
- mult (funct 011000), MUL_CYCLES=4 -> alu_ctrl=000010 for 4 cycles; busy=1 for 3 cycles, then out_valid=1 in cycle 4. in_ready=0 for cycles 1-3; an or (opcode 001101) offered meanwhile is accepted in cycle 4, giving 000100 in cycle 5.
- div (funct 011010), DIV_CYCLES=8, stall high for 3 cycles mid-hold -> code 000011 held 11 cycles, out_valid exactly once, and never while stall=1.
- flush in 2nd cycle of a mult -> next cycle IDLE, alu_ctrl=000000, busy=0, no out_valid pulse.
- opcode 111111 -> alu_ctrl=000000 with out_valid=1 and illegal=1 for one cycle. opcode 000011 (jal) -> 100000, illegal=0. beq (000100) -> 000001.
- rst_n low asynchronously mid-div -> outputs go to reset values immediately. After release, a new add is accepted on the first edge.
